// File: rtl/control_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : control_unit_pkg
//  Purpose  : Shared opcode classes, full opcodes and ALU op encodings for
//             the 6-bit CPU control unit.
//  Revision : 1.0 - initial release
// ============================================================================
package control_unit_pkg;

  // Opcode class field (opcode[3:2])
  localparam logic [1:0] ALU_RR  = 2'b00;
  localparam logic [1:0] ALU_IMM = 2'b01;
  localparam logic [1:0] JUMP    = 2'b10;
  localparam logic [1:0] MISC    = 2'b11;

  // Full opcodes with dedicated behaviour
  localparam logic [3:0] JMP  = 4'b1000;
  localparam logic [3:0] JS   = 4'b1001;
  localparam logic [3:0] JZ   = 4'b1010;
  localparam logic [3:0] JC   = 4'b1011;
  localparam logic [3:0] HALT = 4'b1111;

  // ALU operation encodings
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  // Class field of an opcode
  function automatic logic [1:0] opcode_class(input logic [3:0] opc);
    return opc[3:2];
  endfunction

endpackage : control_unit_pkg
`default_nettype wire

// File: rtl/control_decode.sv
`default_nettype none
// ============================================================================
//  Module   : control_decode
//  Purpose  : Purely combinational opcode/flag decoder producing the next
//             control-signal set and a halt request.
//  Revision : 1.0 - initial release
// ============================================================================
module control_decode
  import control_unit_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic       cf,
  input  logic       sf,
  input  logic       zf,
  output logic [1:0] o_op,
  output logic       o_jmp_sel,
  output logic       o_imm_sel,
  output logic       o_reg_en,
  output logic       o_halt_req
);

  // Decode class and sub-field; everything defaults to the all-zero NOP set
  always_comb begin
    o_op       = OP_ADD;
    o_jmp_sel  = 1'b0;
    o_imm_sel  = 1'b0;
    o_reg_en   = 1'b0;
    o_halt_req = 1'b0;
    case (opcode_class(opcode))
      ALU_RR: begin
        o_op     = opcode[1:0];
        o_reg_en = 1'b1;
      end
      ALU_IMM: begin
        o_op      = opcode[1:0];
        o_imm_sel = 1'b1;
        o_reg_en  = 1'b1;
      end
      JUMP: begin
        // Flags matter only here
        case (opcode)
          JMP:     o_jmp_sel = 1'b1;
          JS:      o_jmp_sel = sf;
          JZ:      o_jmp_sel = zf;
          JC:      o_jmp_sel = cf;
          default: o_jmp_sel = 1'b0;
        endcase
      end
      default: begin
        // MISC: NOPs leave the defaults; HALT additionally requests halt
        o_halt_req = (opcode == HALT);
      end
    endcase
  end

endmodule : control_decode
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : control_unit
//  Purpose  : Instruction decoder / control generator with registered
//             outputs and a sticky halt flag cleared only by reset.
//  Revision : 1.0 - initial release
// ============================================================================
module control_unit
  import control_unit_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  input  logic       cf,
  input  logic       sf,
  input  logic       zf,
  output logic [1:0] op,
  output logic       jmp_sel,
  output logic       imm_sel,
  output logic       reg_en,
  output logic       halted
);

  logic [1:0] w_op;
  logic       w_jmp_sel;
  logic       w_imm_sel;
  logic       w_reg_en;
  logic       w_halt_req;

  logic [1:0] r_op;
  logic       r_jmp_sel;
  logic       r_imm_sel;
  logic       r_reg_en;
  logic       r_halted;

  control_decode u_decode (
    .opcode     (opcode),
    .cf         (cf),
    .sf         (sf),
    .zf         (zf),
    .o_op       (w_op),
    .o_jmp_sel  (w_jmp_sel),
    .o_imm_sel  (w_imm_sel),
    .o_reg_en   (w_reg_en),
    .o_halt_req (w_halt_req)
  );

  // Register decoded controls; once halted, force controls to zero until reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op      <= OP_ADD;
      r_jmp_sel <= 1'b0;
      r_imm_sel <= 1'b0;
      r_reg_en  <= 1'b0;
      r_halted  <= 1'b0;
    end else if (r_halted) begin
      r_op      <= OP_ADD;
      r_jmp_sel <= 1'b0;
      r_imm_sel <= 1'b0;
      r_reg_en  <= 1'b0;
    end else begin
      r_op      <= w_op;
      r_jmp_sel <= w_jmp_sel;
      r_imm_sel <= w_imm_sel;
      r_reg_en  <= w_reg_en;
      r_halted  <= w_halt_req;
    end
  end

  assign op      = r_op;
  assign jmp_sel = r_jmp_sel;
  assign imm_sel = r_imm_sel;
  assign reg_en  = r_reg_en;
  assign halted  = r_halted;

endmodule : control_unit
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_control_unit
//  Purpose  : Self-checking bench for control_unit. Observed outputs are
//             packed as {halted, op[1:0], jmp_sel, imm_sel, reg_en}.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_control_unit;

  logic       clk;
  logic       rst;
  logic [3:0] opcode;
  logic       cf;
  logic       sf;
  logic       zf;
  logic [1:0] op;
  logic       jmp_sel;
  logic       imm_sel;
  logic       reg_en;
  logic       halted;

  int n_cmp;
  int n_bad;

  control_unit dut (
    .clk     (clk),
    .rst     (rst),
    .opcode  (opcode),
    .cf      (cf),
    .sf      (sf),
    .zf      (zf),
    .op      (op),
    .jmp_sel (jmp_sel),
    .imm_sel (imm_sel),
    .reg_en  (reg_en),
    .halted  (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] obs();
    return {halted, op, jmp_sel, imm_sel, reg_en};
  endfunction

  task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Reference: expected {halted, op, jmp, imm, reg_en} for a non-halted unit
  function automatic logic [5:0] ref_dec(input logic [3:0] o, input logic c,
                                         input logic s, input logic z);
    logic [5:0] r;
    r = 6'b0;
    if (o[3:2] == 2'b00)      r = {1'b0, o[1:0], 3'b001};
    else if (o[3:2] == 2'b01) r = {1'b0, o[1:0], 3'b011};
    else if (o == 4'b1000)    r = 6'b000100;
    else if (o == 4'b1001)    r = {3'b000, s, 2'b00};
    else if (o == 4'b1010)    r = {3'b000, z, 2'b00};
    else if (o == 4'b1011)    r = {3'b000, c, 2'b00};
    else if (o == 4'b1111)    r = 6'b100000;
    return r;
  endfunction

  // Drive at negedge, let one rising edge capture, sample 1 time unit later
  task automatic step(input logic [3:0] o, input logic c, input logic s,
                      input logic z, input logic [5:0] exp, input string tag);
    @(negedge clk);
    opcode = o; cf = c; sf = s; zf = z;
    @(posedge clk);
    #1;
    chk(tag, obs(), exp);
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_pulse", obs(), 6'b000000);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [5:0] e;
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1; opcode = 4'b0000; cf = 1'b0; sf = 1'b0; zf = 1'b0;
    #12;
    chk("reset_state", obs(), 6'b000000);
    @(negedge clk);
    rst = 1'b0;

    // Async reset mid-stream
    step(4'b0001, 1'b0, 1'b0, 1'b0, 6'b001001, "sub_rr");
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst", obs(), 6'b000000);
    @(negedge clk);
    rst = 1'b0;

    // ALU reg-reg and immediate
    step(4'b0000, 1'b0, 1'b1, 1'b0, 6'b000001, "add_rr");
    step(4'b0100, 1'b0, 1'b1, 1'b0, 6'b000011, "add_imm");
    step(4'b0111, 1'b1, 1'b1, 1'b1, 6'b011011, "or_imm");
    step(4'b0010, 1'b1, 1'b0, 1'b1, 6'b010001, "and_rr");

    // Unconditional jump
    step(4'b1000, 1'b0, 1'b0, 1'b0, 6'b000100, "jmp_f0");
    step(4'b1000, 1'b1, 1'b1, 1'b1, 6'b000100, "jmp_f7");

    // JS / JZ / JC flag dependence
    step(4'b1001, 1'b0, 1'b1, 1'b0, 6'b000100, "js_s1");
    step(4'b1001, 1'b0, 1'b0, 1'b0, 6'b000000, "js_s0");
    step(4'b1001, 1'b0, 1'b1, 1'b1, 6'b000100, "js_s1z1");
    step(4'b1001, 1'b1, 1'b0, 1'b1, 6'b000000, "js_s0cz");
    step(4'b1010, 1'b0, 1'b0, 1'b1, 6'b000100, "jz_z1");
    step(4'b1010, 1'b0, 1'b0, 1'b0, 6'b000000, "jz_z0");
    step(4'b1010, 1'b1, 1'b1, 1'b0, 6'b000000, "jz_z0cs");
    step(4'b1011, 1'b1, 1'b0, 1'b0, 6'b000100, "jc_c1");
    step(4'b1011, 1'b0, 1'b0, 1'b0, 6'b000000, "jc_c0");
    step(4'b1011, 1'b0, 1'b1, 1'b1, 6'b000000, "jc_c0sz");

    // NOP
    step(4'b1100, 1'b1, 1'b1, 1'b1, 6'b000000, "nop_c");
    step(4'b1110, 1'b1, 1'b1, 1'b1, 6'b000000, "nop_e");

    // Flag change between edges must not matter until the next edge
    step(4'b1010, 1'b0, 1'b0, 1'b1, 6'b000100, "jz_hold_a");
    #2;
    zf = 1'b0;
    #1;
    chk("jz_between", obs(), 6'b000100);

    // HALT is sticky
    step(4'b1111, 1'b0, 1'b0, 1'b0, 6'b100000, "halt");
    step(4'b0000, 1'b0, 1'b0, 1'b0, 6'b100000, "halt_hold_add");
    step(4'b1000, 1'b1, 1'b1, 1'b1, 6'b100000, "halt_hold_jmp");
    pulse_rst();
    step(4'b0000, 1'b0, 1'b0, 1'b0, 6'b000001, "post_halt_add");

    // Full sweep: 16 opcodes x 8 flag combinations
    for (int o = 0; o < 16; o++) begin
      for (int f = 0; f < 8; f++) begin
        e = ref_dec(4'(o), f[2], f[1], f[0]);
        step(4'(o), f[2], f[1], f[0], e, $sformatf("sweep_o%0d_f%0d", o, f));
        if (e[5]) pulse_rst();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_control_unit
`default_nettype wire
